// File: rtl/gmii_tx_pkg.sv
// Shared GMII transmit constants and state encoding.
// Imported by the MAC TX datapath and the CRC helper.
package gmii_tx_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_PAYLOAD,
    S_PAD,
    S_FCS,
    S_IFG,
    S_DRAIN
  } tx_state_t;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
endpackage

// File: rtl/gmii_mac_tx_crc32_byte.sv
// Combinational CRC-32 (reflected) update over one byte.
// Shared with the receive-side FCS checker.
module crc32_byte
  import gmii_tx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);
  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 8; i++) begin
      if (crc_next[0] ^ data[i])
        crc_next = (crc_next >> 1) ^ CRC32_POLY;
      else
        crc_next = crc_next >> 1;
    end
  end
endmodule

// File: rtl/gmii_mac_tx.sv
// MAC-side GMII/MII transmitter: preamble, SFD, pad, FCS, IFG.
// MII mode sends each byte as two nibbles, low nibble first.
module gmii_mac_tx
  import gmii_tx_pkg::*;
#(
  parameter int ENABLE_PADDING   = 1,
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int IFG_BYTES        = 12
) (
  input  logic       mac_gmii_tx_clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] mac_gmii_txd,
  output logic       mac_gmii_tx_en,
  output logic       mac_gmii_tx_er,
  input  logic       mii_select,
  output logic       start_packet,
  output logic       error_underflow
);
  localparam logic [15:0] PAD_LEN  = 16'(MIN_FRAME_LENGTH - 4);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
  localparam bit          PAD_EN   = (ENABLE_PADDING != 0);

  tx_state_t   state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [15:0] len, len_n, len_inc;
  logic [31:0] crc, crc_n, crc_upd, fcs;
  logic [7:0]  crc_din, byte_n, fcs_byte;
  logic        en_n, er_n, sp_n, uf_n;
  logic        mii_r, mii_eff, hi, strobe;
  logic [3:0]  hold_hi;

  // mode follows the pin only while idle, then is frozen
  assign mii_eff  = (state == S_IDLE) ? mii_select : mii_r;
  assign strobe   = !mii_eff || !hi;
  assign len_inc  = (&len) ? len : len + 16'd1;
  assign fcs      = ~crc;
  assign fcs_byte = fcs[8*cnt[1:0] +: 8];
  assign crc_din  = (state == S_PAYLOAD) ? s_axis_tdata : 8'h00;

  assign s_axis_tready = (state == S_PAYLOAD && strobe)
                      || (state == S_DRAIN);

  crc32_byte u_crc (
    .crc      (crc),
    .data     (crc_din),
    .crc_next (crc_upd)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len;
    crc_n   = crc;
    byte_n  = 8'h00;
    en_n    = 1'b0;
    er_n    = 1'b0;
    sp_n    = 1'b0;
    uf_n    = 1'b0;
    unique case (state)
      S_IDLE: begin
        len_n = '0;
        crc_n = CRC32_INIT;
        if (strobe && s_axis_tvalid) begin
          state_n = S_PREAMBLE;
          cnt_n   = 8'd1;
          byte_n  = ETH_PREAMBLE;
          en_n    = 1'b1;
        end
      end
      S_PREAMBLE: if (strobe) begin
        byte_n = ETH_PREAMBLE;
        en_n   = 1'b1;
        cnt_n  = cnt + 8'd1;
        if (cnt == 8'd6) state_n = S_SFD;
      end
      S_SFD: if (strobe) begin
        byte_n  = ETH_SFD;
        en_n    = 1'b1;
        sp_n    = 1'b1;
        state_n = S_PAYLOAD;
      end
      S_PAYLOAD: if (strobe) begin
        en_n = 1'b1;
        if (s_axis_tvalid) begin
          byte_n = s_axis_tdata;
          crc_n  = crc_upd;
          len_n  = len_inc;
          er_n   = s_axis_tlast && s_axis_tuser;
          if (s_axis_tlast) begin
            cnt_n   = '0;
            state_n = (PAD_EN && len_inc < PAD_LEN) ? S_PAD : S_FCS;
          end
        end else begin
          er_n    = 1'b1;
          uf_n    = 1'b1;
          state_n = S_DRAIN;
        end
      end
      S_PAD: if (strobe) begin
        en_n  = 1'b1;
        crc_n = crc_upd;
        len_n = len_inc;
        if (len_inc >= PAD_LEN) begin
          cnt_n   = '0;
          state_n = S_FCS;
        end
      end
      S_FCS: if (strobe) begin
        byte_n = fcs_byte;
        en_n   = 1'b1;
        cnt_n  = cnt + 8'd1;
        if (cnt == 8'd3) begin
          cnt_n   = '0;
          state_n = S_IFG;
        end
      end
      S_IFG: if (strobe) begin
        cnt_n = cnt + 8'd1;
        if (cnt == IFG_LAST) state_n = S_IDLE;
      end
      S_DRAIN: if (s_axis_tvalid && s_axis_tlast) begin
        // an idle byte loaded on this strobe already counts as gap
        state_n = S_IFG;
        cnt_n   = strobe ? 8'd1 : 8'd0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge mac_gmii_tx_clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      len             <= '0;
      crc             <= CRC32_INIT;
      mii_r           <= 1'b0;
      hi              <= 1'b0;
      hold_hi         <= '0;
      mac_gmii_txd    <= '0;
      mac_gmii_tx_en  <= 1'b0;
      mac_gmii_tx_er  <= 1'b0;
      start_packet    <= 1'b0;
      error_underflow <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      len             <= len_n;
      crc             <= crc_n;
      mii_r           <= mii_eff;
      hi              <= mii_eff && !hi;
      start_packet    <= sp_n;
      error_underflow <= uf_n;
      if (strobe) begin
        hold_hi        <= byte_n[7:4];
        mac_gmii_tx_en <= en_n;
        mac_gmii_tx_er <= er_n;
        mac_gmii_txd   <= mii_eff ? {4'h0, byte_n[3:0]} : byte_n;
      end else begin
        mac_gmii_txd <= {4'h0, hold_hi};
      end
    end
  end
endmodule
